usb_rx_unstuff_shift: RTL and testbench

- Receive-path stage directly downstream of the NRZI decoder.
- Consumes the decoded bit stream (data_bit, qualified by shift_enable) and hunts for the USB SYNC pattern.
- After SYNC: removes stuffed bits, assembles bytes LSB-first, and presents each byte with a one-cycle strobe.
- Flags bit-stuff violations and misaligned end-of-packet for the packet-level controller.

---
 rtl/usb_rx_unstuff_shift_if.sv | 28 ++
 rtl/usb_rx_unstuff_shift.sv | 133 +++++++++++++
 tb/tb_usb_rx_unstuff_shift.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/usb_rx_unstuff_shift_if.sv
`default_nettype none
// ============================================================================
// usb_rx_unstuff_shift_if
// Bit-stream in / byte-strobe out bundle for the USB RX unstuff/shift stage.
// Revision: 1.0
// ============================================================================
interface usb_rx_unstuff_shift_if;
  logic       data_bit;
  logic       shift_enable;
  logic       eop;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       receiving;
  logic       stuff_error;
  logic       align_error;

  // master drives the decoded bit stream (NRZI decoder / EOP detector side)
  modport master (
    output data_bit, shift_enable, eop,
    input  rx_data, byte_ready, receiving, stuff_error, align_error
  );

  modport slave (
    input  data_bit, shift_enable, eop,
    output rx_data, byte_ready, receiving, stuff_error, align_error
  );
endinterface
`default_nettype wire

// File: rtl/usb_rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// usb_rx_unstuff_shift
// SYNC hunt, bit unstuffing and LSB-first byte assembly after NRZI decode.
// Revision: 1.0
// ============================================================================
module usb_rx_unstuff_shift #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned MAX_ONES     = 6
) (
  input wire logic               clk,
  input wire logic               rst,
  usb_rx_unstuff_shift_if.slave  rx
);

  localparam int unsigned     c_ONES_W    = $clog2(MAX_ONES + 1);
  localparam logic [7:0]      c_IDLE_HIST = 8'hFF;
  localparam logic [c_ONES_W-1:0] c_ONES_MAX = c_ONES_W'(MAX_ONES);
  localparam logic [c_ONES_W-1:0] c_ONES_ONE = c_ONES_W'(1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_RECV = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [7:0]            r_history,    w_history_nxt;
  logic [7:0]            r_sr,         w_sr_nxt;
  logic [2:0]            r_bit_cnt,    w_bit_cnt_nxt;
  logic [c_ONES_W-1:0]   r_ones_cnt,   w_ones_cnt_nxt;
  logic [7:0]            r_rx_data,    w_rx_data_nxt;
  logic                  r_byte_ready, w_byte_ready_nxt;
  logic                  r_align_err,  w_align_err_nxt;

  logic [7:0]            w_hist_shift;
  logic [7:0]            w_sr_shift;

  assign w_hist_shift = {rx.data_bit, r_history[7:1]};
  assign w_sr_shift   = {rx.data_bit, r_sr[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_history    <= c_IDLE_HIST;
      r_sr         <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_ones_cnt   <= '0;
      r_rx_data    <= 8'h00;
      r_byte_ready <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_history    <= w_history_nxt;
      r_sr         <= w_sr_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_ones_cnt   <= w_ones_cnt_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_byte_ready <= w_byte_ready_nxt;
      r_align_err  <= w_align_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_history_nxt    = r_history;
    w_sr_nxt         = r_sr;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_ones_cnt_nxt   = r_ones_cnt;
    w_rx_data_nxt    = r_rx_data;
    w_byte_ready_nxt = 1'b0;
    w_align_err_nxt  = 1'b0;

    unique case (r_state)
      S_HUNT: begin
        if (rx.shift_enable) begin
          w_history_nxt = w_hist_shift;
          // The closing SYNC 1 already counts toward the stuffing run.
          if (w_hist_shift == SYNC_PATTERN) begin
            w_state_nxt    = S_RECV;
            w_bit_cnt_nxt  = 3'd0;
            w_ones_cnt_nxt = c_ONES_ONE;
          end
        end
      end

      S_RECV: begin
        if (rx.eop) begin
          w_state_nxt     = S_HUNT;
          w_history_nxt   = c_IDLE_HIST;
          w_align_err_nxt = (r_bit_cnt != 3'd0);
          w_bit_cnt_nxt   = 3'd0;
        end else if (rx.shift_enable) begin
          if (r_ones_cnt == c_ONES_MAX) begin
            if (rx.data_bit) begin
              w_state_nxt   = S_ERR;
              w_history_nxt = c_IDLE_HIST;
            end else begin
              w_ones_cnt_nxt = '0;
            end
          end else begin
            w_sr_nxt       = w_sr_shift;
            w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
            w_ones_cnt_nxt = rx.data_bit ? (r_ones_cnt + c_ONES_ONE) : '0;
            if (r_bit_cnt == 3'd7) begin
              w_rx_data_nxt    = w_sr_shift;
              w_byte_ready_nxt = 1'b1;
            end
          end
        end
      end

      S_ERR: begin
        if (rx.eop) begin
          w_state_nxt = S_HUNT;
        end
      end

      default: begin
        w_state_nxt   = S_HUNT;
        w_history_nxt = c_IDLE_HIST;
      end
    endcase
  end

  assign rx.rx_data     = r_rx_data;
  assign rx.byte_ready  = r_byte_ready;
  assign rx.align_error = r_align_err;
  assign rx.receiving   = (r_state == S_RECV);
  assign rx.stuff_error = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// tb_usb_rx_unstuff_shift
// Directed stimulus with a byte scoreboard for usb_rx_unstuff_shift.
// Revision: 1.0
// ============================================================================
module tb_usb_rx_unstuff_shift;

  logic clk;
  logic rst;

  usb_rx_unstuff_shift_if rx_if ();

  usb_rx_unstuff_shift #(
    .SYNC_PATTERN (8'h80),
    .MAX_ONES     (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_err;
  int         exp_align;
  int         act_align;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every byte_ready pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_if.byte_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte_ready: got rx_data %0h expected no byte", rx_if.rx_data);
        end else begin
          chk("rx_data", rx_if.rx_data, exp_q.pop_front());
        end
      end
      if (rx_if.align_error === 1'b1) act_align++;
    end
  end

  // Sends n bits of v, v[0] first; entered and left on a negedge.
  // Between strobes data_bit wiggles to prove it is ignored without shift_enable.
  task automatic send_vec(input logic [15:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_if.data_bit     = v[i];
      rx_if.shift_enable = 1'b1;
      @(negedge clk);
      rx_if.shift_enable = 1'b0;
      for (int g = 1; g < gap; g++) begin
        rx_if.data_bit = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
  endtask

  task automatic send_sync(input int gap);
    send_vec(16'h00FF, 8, gap);
    send_vec(16'h0080, 7, gap);
    chk("receiving_before_last_sync", {7'd0, rx_if.receiving}, 8'd0);
    send_vec(16'h0001, 1, gap);
    chk("receiving_after_sync", {7'd0, rx_if.receiving}, 8'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    exp_q.push_back(b);
    send_vec({8'h00, b}, 8, gap);
  endtask

  task automatic pulse_eop();
    rx_if.eop = 1'b1;
    @(negedge clk);
    rx_if.eop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_align = 0; act_align = 0;
    rst = 1'b1;
    rx_if.data_bit = 1'b0; rx_if.shift_enable = 1'b0; rx_if.eop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_if.rx_data, 8'h00);
    chk("reset_flags", {4'd0, rx_if.byte_ready, rx_if.receiving,
                        rx_if.stuff_error, rx_if.align_error}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Basic SYNC + A5, 4 clk between strobes
    send_sync(4);
    send_byte(8'hA5, 4);
    chk("recv_after_byte", {7'd0, rx_if.receiving}, 8'd1);
    pulse_eop();   // byte-aligned EOP: no align_error
    chk("recv_after_eop", {7'd0, rx_if.receiving}, 8'd0);

    // Stuffed bit after 5 data 1s (SYNC 1 counts): 1,1,1,1,1,0s,1,0,0
    send_sync(2);
    exp_q.push_back(8'h3F);
    send_vec(16'h005F, 9, 2);
    pulse_eop();

    // Six 1s -> stuff error, strobes ignored, eop clears
    send_sync(2);
    send_vec(16'h003F, 6, 2);
    chk("stuff_error_set", {6'd0, rx_if.stuff_error, rx_if.receiving}, 8'b10);
    send_vec(16'h00AA, 8, 1);
    chk("stuff_error_held", {6'd0, rx_if.stuff_error, rx_if.receiving}, 8'b10);
    pulse_eop();
    chk("stuff_error_clear", {6'd0, rx_if.stuff_error, rx_if.receiving}, 8'b00);

    // Byte 00, 3 bits, eop coincident with 4th strobe -> align_error
    send_sync(2);
    send_byte(8'h00, 2);
    send_vec(16'h0005, 3, 2);
    exp_align++;
    rx_if.eop = 1'b1; rx_if.data_bit = 1'b1; rx_if.shift_enable = 1'b1;
    @(negedge clk);
    rx_if.eop = 1'b0; rx_if.shift_enable = 1'b0;
    chk("align_error_pulse", {7'd0, rx_if.align_error}, 8'd1);
    @(negedge clk);
    chk("align_error_clear", {7'd0, rx_if.align_error}, 8'd0);
    chk("rx_data_kept", rx_if.rx_data, 8'h00);
    chk("recv_after_align", {7'd0, rx_if.receiving}, 8'd0);

    // Asynchronous reset mid-packet
    send_sync(2);
    send_vec(16'h000F, 4, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {4'd0, rx_if.byte_ready, rx_if.receiving,
                            rx_if.stuff_error, rx_if.align_error}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_sync(3);
    send_byte(8'hC3, 3);
    chk("rx_data_after_rst", rx_if.rx_data, 8'hC3);
    pulse_eop();

    // 5A back-to-back, then with 7-clk gaps
    send_sync(1);
    send_byte(8'h5A, 1);
    pulse_eop();
    send_sync(7);
    send_byte(8'h5A, 7);
    pulse_eop();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    chk("align_error_count", 8'(act_align), 8'(exp_align));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
